id_stage_ctrl: RTL and testbench
================================

# id_stage_ctrl

Decode-stage pipeline controller for the RV32I core. Accepts fetched instructions from IF over a valid/ready handshake and decodes register indices, format and immediate, using an internal ImmGen instance. Results are held in a single registered slot presented to EX over a second valid/ready handshake. Also detects load-use hazards against the instruction in the slot, inserts a one-cycle bubble, honours pipeline flush, and counts hazard stall cycles.

## Interface
- CNT_W, 16, width of the stall counter (saturating)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  ID accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- flush  in  1  synchronous kill of the slot and any IF transfer this cycle
- ex_valid  out  1  slot holds a valid decoded instruction
- ex_ready  in  1  EX accepts the slot this cycle
- ex_pc, ex_instr  out  32 each  registered copies
- ex_imm  out  32  ImmGen result for ex_instr
- ex_rs1, ex_rs2, ex_rd  out  5 each  instr[19:15], [24:20], [11:7]
- ex_is_load  out  1  opcode == OPC_LOAD
- ex_illegal  out  1  opcode is not a defined RV32I opcode
- stall_cnt  out  CNT_W  load-use stall cycles, saturating

## Operation
- Slot FSM has 2 states: EMPTY (ex_valid=0) and FULL (ex_valid=1).
- advance = !ex_valid | ex_ready.
- Legal opcodes: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_ITYPE, and OP (7'b0110011). Any other opcode sets ex_illegal=1 and ex_imm=0; the instruction still flows.
- uses_rs1: JALR, BRANCH, LOAD, STORE, ITYPE, OP.
- uses_rs2: BRANCH, STORE, OP.
- hazard = if_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((uses_rs1(if_instr) & rs1 == ex_rd) | (uses_rs2(if_instr) & rs2 == ex_rd)).
- if_ready = advance & !hazard & !flush. This path is combinational; there is no skid buffer.
- Transitions:
  - flush: next state is EMPTY regardless of other inputs.
  - if_valid & if_ready: load the slot from if_* plus decode; next state FULL.
  - advance with no accept (including the hazard case): next state EMPTY, which is the bubble.
  - otherwise: hold the slot unchanged.
- When the slot is FULL and ex_ready=0, every ex_* output stays stable.
- A hazard never stalls longer than the load's EX handshake. Once the slot empties, the hazard condition clears and the dependent instruction is accepted the next cycle.
- stall_cnt increments on each cycle with hazard & !flush and saturates at all-ones.

## Timing
- Reset, asynchronous: state EMPTY; ex_valid=0; all ex_* data outputs 0; stall_cnt=0; if_ready=0 while rst_n is low.
- Latency: an IF handshake at edge N gives ex_valid=1 with the decoded data after edge N.
- Throughput is 1 instruction/cycle when there are no hazards and ex_ready is held at 1.
- A load-use pair costs exactly 1 bubble cycle when ex_ready=1.
- Simultaneous flush with an IF handshake: the IF transfer is suppressed (if_ready=0) and the slot empties.
- Flush while the slot is FULL and ex_ready=1: EX still sees that cycle's transfer. The flush only affects state from the next edge.
- rst_n asserted mid-operation: the slot is dropped immediately and the counter clears.

## Test plan
- Reset, then stream with ex_ready=1:
  - 0xFFF00093 (addi) -> ex_imm=0xFFFFFFFF, ex_rd=1
  - 0x0020A423 (sw) -> ex_imm=8, rs1=1, rs2=2
  - 0xFE000EE3 (beq) -> ex_imm=0xFFFFFFFC
  - 0x123451B7 (lui) -> ex_imm=0x12345000
  - All four leave on consecutive cycles.
- Load-use: 0x0000A283 (lw x5) then 0x00228333 (add x6,x5,x2) -> if_ready=0 for 1 cycle, 1 ex_valid=0 bubble between them, stall_cnt=1.
- No false hazard:
  - lw to x0 followed by an add reading x0 -> no stall.
  - lw x5 followed by lui x5 -> no stall, since lui has no rs use.
- Backpressure: ex_ready=0 for 3 cycles with the slot FULL -> ex_* stable, if_ready=0; ex_ready=1 -> the next instruction is accepted the same cycle.
- 0x00000000 -> ex_illegal=1, ex_imm=0. Flush asserted together with if_valid -> the instruction is dropped and ex_valid=0 the next cycle.
- Drive stall_cnt to saturation with CNT_W=4 -> it holds at 0xF. Assert rst_n=0 mid-stream -> ex_valid and stall_cnt go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: one registered slot between IF and EX. It decodes each
// instruction, inserts a one-cycle bubble on a load-use hazard and counts stall cycles.

module id_imm_gen (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic        legal_o
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  always_comb begin
    imm_o   = 32'd0;
    legal_o = 1'b1;
    unique case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'd0};
      OPC_JAL:
        imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_ITYPE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_BRANCH:
        imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_OP:
        imm_o = 32'd0;
      default: begin
        imm_o   = 32'd0;
        legal_o = 1'b0;
      end
    endcase
  end
endmodule

module id_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_is_load,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e           state_q;
  logic [31:0]      ex_pc_q, ex_instr_q, ex_imm_q;
  logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic             ex_is_load_q, ex_illegal_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [6:0]  if_opc;
  logic [31:0] dec_imm;
  logic        dec_legal;
  logic        uses_rs1, uses_rs2;
  logic        advance, hazard, accept;

  id_imm_gen u_imm_gen (
    .instr_i (if_instr),
    .imm_o   (dec_imm),
    .legal_o (dec_legal)
  );

  assign if_opc   = if_instr[6:0];
  assign uses_rs1 = (if_opc == OPC_JALR)  | (if_opc == OPC_BRANCH) | (if_opc == OPC_LOAD) |
                    (if_opc == OPC_STORE) | (if_opc == OPC_ITYPE)  | (if_opc == OPC_OP);
  assign uses_rs2 = (if_opc == OPC_BRANCH) | (if_opc == OPC_STORE) | (if_opc == OPC_OP);

  assign ex_valid = (state_q == S_FULL);
  assign advance  = !ex_valid | ex_ready;
  assign hazard   = if_valid & ex_valid & ex_is_load_q & (ex_rd_q != 5'd0) &
                    ((uses_rs1 & (if_instr[19:15] == ex_rd_q)) |
                     (uses_rs2 & (if_instr[24:20] == ex_rd_q)));
  // rst_n gates the handshake so IF never sees ready while the core is held in reset.
  assign if_ready = rst_n & advance & !hazard & !flush;
  assign accept   = if_valid & if_ready;

  assign stall_cnt_d = (hazard && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      ex_pc_q      <= 32'd0;
      ex_instr_q   <= 32'd0;
      ex_imm_q     <= 32'd0;
      ex_rs1_q     <= 5'd0;
      ex_rs2_q     <= 5'd0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
      ex_illegal_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush) begin
        state_q <= S_EMPTY;
      end else if (accept) begin
        state_q      <= S_FULL;
        ex_pc_q      <= if_pc;
        ex_instr_q   <= if_instr;
        ex_imm_q     <= dec_imm;
        ex_rs1_q     <= if_instr[19:15];
        ex_rs2_q     <= if_instr[24:20];
        ex_rd_q      <= if_instr[11:7];
        ex_is_load_q <= (if_opc == OPC_LOAD);
        ex_illegal_q <= !dec_legal;
      end else if (advance) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign ex_pc      = ex_pc_q;
  assign ex_instr   = ex_instr_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_illegal = ex_illegal_q;
  assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: decode stream, load-use bubble, backpressure,
// illegal/flush handling, counter saturation and asynchronous reset.

module tb_id_stage_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_valid, if_ready, flush, ex_valid, ex_ready;
  logic [31:0]      if_instr, if_pc, ex_pc, ex_instr, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_is_load, ex_illegal;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  id_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_pc      (ex_pc),
    .ex_instr   (ex_instr),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_illegal (ex_illegal),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    flush = 1'b0; ex_ready = 1'b1;
    #2;
    if_valid = 1'b1;
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    if_valid = 1'b0;
    #8;
    rst_n = 1'b1;

    // Back-to-back stream with EX always ready
    tick();
    drive(1'b1, 32'hFFF00093, 32'h100);
    chk("addi_if_ready", 32'(if_ready), 32'd1);
    $display("txn addi  pc=0x100");
    tick();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_pc", ex_pc, 32'h100);
    drive(1'b1, 32'h0020A423, 32'h104);
    $display("txn sw    pc=0x104");
    tick();
    chk("sw_valid", 32'(ex_valid), 32'd1);
    chk("sw_imm", ex_imm, 32'd8);
    chk("sw_rs1", 32'(ex_rs1), 32'd1);
    chk("sw_rs2", 32'(ex_rs2), 32'd2);
    drive(1'b1, 32'hFE000EE3, 32'h108);
    $display("txn beq   pc=0x108");
    tick();
    chk("beq_valid", 32'(ex_valid), 32'd1);
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("beq_pc", ex_pc, 32'h108);
    drive(1'b1, 32'h123451B7, 32'h10C);
    $display("txn lui   pc=0x10C");
    tick();
    chk("lui_valid", 32'(ex_valid), 32'd1);
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", 32'(ex_rd), 32'd3);
    chk("lui_illegal", 32'(ex_illegal), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("stream_drained", 32'(ex_valid), 32'd0);

    // Load-use: lw x5 then add x6,x5,x2
    drive(1'b1, 32'h0000A283, 32'h200);
    chk("lw_if_ready", 32'(if_ready), 32'd1);
    $display("txn lw x5 pc=0x200");
    tick();
    chk("lw_valid", 32'(ex_valid), 32'd1);
    chk("lw_is_load", 32'(ex_is_load), 32'd1);
    chk("lw_rd", 32'(ex_rd), 32'd5);
    drive(1'b1, 32'h00228333, 32'h204);
    chk("hazard_if_ready", 32'(if_ready), 32'd0);
    tick();
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("post_bubble_if_ready", 32'(if_ready), 32'd1);
    $display("txn add x6,x5,x2 pc=0x204 after 1 bubble");
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_rd", 32'(ex_rd), 32'd6);
    chk("add_rs1", 32'(ex_rs1), 32'd5);
    chk("add_is_load", 32'(ex_is_load), 32'd0);

    // No false hazard: load to x0, then lui after load
    drive(1'b1, 32'h0000A003, 32'h210);
    $display("txn lw x0 pc=0x210");
    tick();
    drive(1'b1, 32'h00000333, 32'h214);
    chk("x0_no_stall", 32'(if_ready), 32'd1);
    $display("txn add x6,x0,x0 pc=0x214");
    tick();
    chk("x0_add_valid", 32'(ex_valid), 32'd1);
    chk("x0_add_pc", ex_pc, 32'h214);
    drive(1'b1, 32'h0000A283, 32'h218);
    $display("txn lw x5 pc=0x218");
    tick();
    drive(1'b1, 32'h000282B7, 32'h21C);
    chk("lui_no_stall", 32'(if_ready), 32'd1);
    $display("txn lui x5 pc=0x21C");
    tick();
    chk("lui5_imm", ex_imm, 32'h00028000);
    chk("lui5_pc", ex_pc, 32'h21C);
    chk("no_false_stall_cnt", 32'(stall_cnt), 32'd1);

    // Backpressure with the lui held in the slot
    ex_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h300);
    chk("bp_if_ready", 32'(if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_pc", ex_pc, 32'h21C);
      chk("bp_imm", ex_imm, 32'h00028000);
      chk("bp_if_ready_hold", 32'(if_ready), 32'd0);
      $display("txn backpressure cycle %0d", i);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_if_ready", 32'(if_ready), 32'd1);
    tick();
    chk("bp_next_pc", ex_pc, 32'h300);
    chk("bp_next_imm", ex_imm, 32'hFFFFFFFF);

    // Illegal opcode, then flush together with an IF request
    drive(1'b1, 32'h00000000, 32'h400);
    $display("txn illegal pc=0x400");
    tick();
    chk("ill_valid", 32'(ex_valid), 32'd1);
    chk("ill_flag", 32'(ex_illegal), 32'd1);
    chk("ill_imm", ex_imm, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h404);
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    $display("txn flush with if_valid pc=0x404");
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);

    // Counter saturation: load held in slot with a dependent instruction waiting
    drive(1'b1, 32'h0000A283, 32'h500);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, 32'h00228333, 32'h504);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
    chk("sat_valid", 32'(ex_valid), 32'd1);
    chk("sat_pc", ex_pc, 32'h500);
    $display("txn stall counter saturated");

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(ex_valid), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_if_ready", 32'(if_ready), 32'd0);
    $display("txn async reset mid-stream");
    if_valid = 1'b0;
    ex_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
